// File: rtl/uart_rx.sv
// uart_rx -- single-clock UART receiver, 8N1, LSB first.
//
// The asynchronous rx line is double-flopped, then sampled by an FSM paced
// by a 16x oversample tick derived from CLKF/BR. Received bytes are offered
// on a valid/ready interface.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high
//   rx        in   serial line, idles high
//   data      out  received byte, stable while valid is high
//   valid     out  byte available on data
//   ready     in   consumer accepts the byte (transfer on valid && ready)
//   frame_err out  one-cycle pulse: stop bit sampled low
//   overrun   out  one-cycle pulse: completed byte dropped, holding reg full
//   busy      out  receiver is inside a frame (FSM not idle)

module uart_rx #(
   parameter int unsigned BR   = 115200,
   parameter int unsigned CLKF = 18_432_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   // Guarded so a bad parameter set reaches the $fatal below instead of a
   // divide-by-zero during elaboration.
   localparam int unsigned DIV = (BR == 0 || CLKF == 0) ? 1 : CLKF / (BR * 16);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   generate
      if (BR == 0 || CLKF == 0) begin : g_bad_zero
         $fatal(1, "uart_rx: BR and CLKF must be non-zero");
      end else if (CLKF % (BR * 16) != 0) begin : g_bad_ratio
         $fatal(1, "uart_rx: CLKF must be an exact multiple of 16*BR");
      end else if (DIV < 1) begin : g_bad_div
         $fatal(1, "uart_rx: CLKF/(16*BR) must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    os_q, os_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          fe_q, fe_d;
   logic          ov_q, ov_d;

   logic rx_s;
   logic tick;

   assign rx_s = sync_q[1];
   assign tick = (cnt_q == CNT_MAX);

   always_comb begin
      state_d = state_q;
      sync_d  = {sync_q[0], rx};
      cnt_d   = cnt_q;
      os_d    = os_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = valid_q;
      fe_d    = 1'b0;
      ov_d    = 1'b0;

      // Handshake first; a delivery below may re-set valid in the same cycle.
      if (valid_q && ready) valid_d = 1'b0;

      // Tick divider and oversample counter run only inside a frame, so that
      // entering START always starts from a clean phase.
      if (state_q != S_IDLE) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
         if (tick) os_d = os_q + 4'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            os_d  = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            // 8th tick lands mid start bit; a high line there was a glitch.
            if (tick && os_q == 4'd7) begin
               if (!rx_s) begin
                  state_d = S_DATA;
                  os_d    = '0;
                  bit_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            // os wraps 15->0 on its own, so each 16th tick is the next mid-bit.
            if (tick && os_q == 4'd15) begin
               sh_d  = {rx_s, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick && os_q == 4'd15) begin
               if (rx_s) begin
                  state_d = S_IDLE;
                  if (!valid_q || ready) begin
                     data_d  = sh_q;
                     valid_d = 1'b1;
                  end else begin
                     ov_d = 1'b1;
                  end
               end else begin
                  fe_d    = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // Hold off until the line idles so a long low is not a new start.
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         os_q    <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = fe_q;
   assign overrun   = ov_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BR=115200, CLKF=18.432 MHz (DIV=10).
// Frames are driven bit-accurately on rx; a negedge monitor logs transfers,
// frame_err and overrun pulses with their cycle numbers, and each test compares
// them against times and bytes derived from the frame timeline.

module tb_uart_rx;

   localparam int unsigned BR   = 115200;
   localparam int unsigned CLKF = 18_432_000;
   localparam int DIV  = CLKF / (BR * 16);
   localparam int BITC = 16 * DIV;        // clocks per bit
   localparam int LAT  = 152 * DIV + 2;   // capture edge -> valid / frame_err

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] xfer_dat[$];
   int         xfer_cyc[$];
   int         fe_cyc[$];
   int         ov_cyc[$];

   uart_rx #(.BR(BR), .CLKF(CLKF)) dut (
      .clk(clk), .reset(reset), .rx(rx), .data(data), .valid(valid),
      .ready(ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (valid && ready) begin
            xfer_dat.push_back(data);
            xfer_cyc.push_back(cyc);
         end
         if (frame_err) fe_cyc.push_back(cyc);
         if (overrun) ov_cyc.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic clear_logs();
      xfer_dat.delete(); xfer_cyc.delete(); fe_cyc.delete(); ov_cyc.delete();
   endtask

   // Leave the bench #1 after a rising edge, where frames are started.
   task automatic sync_tx();
      @(posedge clk); #1;
   endtask

   // Wait until edge number c has happened, then settle past the monitor.
   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
      #1;
   endtask

   // Drive one 8N1 frame from #1 after an edge; t0 is the edge that captures
   // the start bit. Ends #1 after an edge with rx left at the stop level.
   task automatic send_frame(input logic [7:0] b, input logic stp, output int t0);
      logic [9:0] f;
      f  = {stp, b, 1'b0};
      t0 = cyc + 1;
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (BITC) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rx = 1'b1; ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", overrun); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_normal();
      int t0;
      ready = 1'b1;
      sync_tx(); clear_logs();
      send_frame(8'hA5, 1'b1, t0);
      wait_cyc(t0 + LAT + 50);
      checks++; if (xfer_cyc.size() !== 1) begin errors++; $display("FAIL normal_count: got %0d valid cycles want 1", xfer_cyc.size()); end
      else begin
         checks++; if (xfer_dat[0] !== 8'hA5) begin errors++; $display("FAIL normal_data: got %h want a5", xfer_dat[0]); end
         checks++; if (xfer_cyc[0] !== t0 + LAT) begin errors++; $display("FAIL normal_time: got %0d want %0d", xfer_cyc[0] - t0, LAT); end
      end
      checks++; if (fe_cyc.size() + ov_cyc.size() !== 0) begin errors++; $display("FAIL normal_flags: got %0d fe/ov pulses want 0", fe_cyc.size() + ov_cyc.size()); end
   endtask

   task automatic test_false_start();
      int t0;
      sync_tx(); clear_logs();
      t0 = cyc + 1;
      rx = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      rx = 1'b1;
      wait_cyc(t0 + 8 * DIV + 1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_busy_hi: got %b want 1", busy); end
      wait_cyc(t0 + 8 * DIV + 2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_busy_lo: got %b want 0", busy); end
      wait_cyc(t0 + LAT + 50);
      checks++; if (xfer_cyc.size() + fe_cyc.size() !== 0) begin errors++; $display("FAIL false_output: got %0d events want 0", xfer_cyc.size() + fe_cyc.size()); end
   endtask

   task automatic test_frame_err();
      int t0, t1;
      sync_tx(); clear_logs();
      send_frame(8'h3C, 1'b0, t0);
      repeat (400) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fe_break_busy: got %b want 1", busy); end
      checks++; if (fe_cyc.size() !== 1) begin errors++; $display("FAIL fe_count: got %0d pulses want 1", fe_cyc.size()); end
      else begin
         checks++; if (fe_cyc[0] !== t0 + LAT) begin errors++; $display("FAIL fe_time: got %0d want %0d", fe_cyc[0] - t0, LAT); end
      end
      checks++; if (valid !== 1'b0 || xfer_cyc.size() !== 0) begin errors++; $display("FAIL fe_valid: got valid=%b xfers=%0d want 0/0", valid, xfer_cyc.size()); end
      rx = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      send_frame(8'h3C, 1'b1, t1);
      wait_cyc(t1 + LAT + 20);
      checks++; if (xfer_cyc.size() !== 1 || xfer_dat[0] !== 8'h3C || xfer_cyc[0] !== t1 + LAT) begin
         errors++; $display("FAIL fe_recover: got %0d xfers first=%h want one 3c at +%0d", xfer_cyc.size(), (xfer_dat.size() > 0) ? xfer_dat[0] : 8'hxx, LAT);
      end
   endtask

   task automatic test_overrun();
      int ta, tb;
      ready = 1'b0;
      sync_tx(); clear_logs();
      send_frame(8'h11, 1'b1, ta);
      send_frame(8'h22, 1'b1, tb);
      wait_cyc(tb + LAT + 10);
      checks++; if (valid !== 1'b1 || data !== 8'h11) begin errors++; $display("FAIL ovr_hold: got valid=%b data=%h want 1/11", valid, data); end
      checks++; if (ov_cyc.size() !== 1) begin errors++; $display("FAIL ovr_count: got %0d pulses want 1", ov_cyc.size()); end
      else begin
         checks++; if (ov_cyc[0] !== tb + LAT) begin errors++; $display("FAIL ovr_time: got %0d want %0d", ov_cyc[0] - tb, LAT); end
      end
      @(posedge clk); #1;
      ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got valid=%b want 0", valid); end
      checks++; if (xfer_dat.size() !== 1 || xfer_dat[0] !== 8'h11) begin errors++; $display("FAIL ovr_xfer: got %0d xfers want one 11", xfer_dat.size()); end
   endtask

   task automatic test_back_to_back();
      int ta, tb;
      ready = 1'b1;
      sync_tx(); clear_logs();
      send_frame(8'h00, 1'b1, ta);
      send_frame(8'hFF, 1'b1, tb);
      wait_cyc(tb + LAT + 20);
      checks++; if (xfer_cyc.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", xfer_cyc.size()); end
      else begin
         checks++; if (xfer_dat[0] !== 8'h00 || xfer_dat[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %h %h want 00 ff", xfer_dat[0], xfer_dat[1]); end
         checks++; if (xfer_cyc[0] !== ta + LAT || xfer_cyc[1] - xfer_cyc[0] !== 10 * BITC) begin
            errors++; $display("FAIL b2b_time: got +%0d gap %0d want +%0d gap %0d", xfer_cyc[0] - ta, xfer_cyc[1] - xfer_cyc[0], LAT, 10 * BITC);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] f;
      int t1;
      ready = 1'b1;
      sync_tx(); clear_logs();
      f = {1'b1, 8'h5A, 1'b0};
      // start bit + data bits 0..3, then half of bit 4
      for (int i = 0; i < 5; i++) begin
         rx = f[i];
         repeat (BITC) @(posedge clk);
         #1;
      end
      rx = f[5];
      repeat (BITC / 2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL rst_mid_outputs: got data=%h valid=%b busy=%b fe=%b ov=%b want 00/0/0/0/0", data, valid, busy, frame_err, overrun);
      end
      rx = 1'b1;
      repeat (400) @(posedge clk);
      #1;
      checks++; if (xfer_cyc.size() !== 0) begin errors++; $display("FAIL rst_mid_partial: got %0d xfers want 0", xfer_cyc.size()); end
      send_frame(8'hC3, 1'b1, t1);
      wait_cyc(t1 + LAT + 20);
      checks++; if (xfer_cyc.size() !== 1 || xfer_dat[0] !== 8'hC3 || xfer_cyc[0] !== t1 + LAT) begin
         errors++; $display("FAIL rst_mid_next: got %0d xfers first=%h want one c3", xfer_cyc.size(), (xfer_dat.size() > 0) ? xfer_dat[0] : 8'hxx);
      end
   endtask

   // Random bytes, random stop validity and random idle gaps; the model is a
   // list of bytes and arrival cycles taken straight from the frame timeline.
   task automatic test_random();
      logic [7:0] exp_dat[$];
      int         exp_cyc[$];
      int         exp_fe[$];
      logic [7:0] b;
      logic       bad;
      int         t0, gap, n;
      ready = 1'b1;
      sync_tx(); clear_logs();
      t0 = 0;
      for (int k = 0; k < 8; k++) begin
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 3) == 0);
         send_frame(b, !bad, t0);
         if (bad) exp_fe.push_back(t0 + LAT);
         else begin
            exp_dat.push_back(b);
            exp_cyc.push_back(t0 + LAT);
         end
         rx  = 1'b1;
         gap = bad ? $urandom_range(20, 200) : $urandom_range(0, 200);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      wait_cyc(t0 + LAT + 20);
      checks++; if (xfer_dat.size() !== exp_dat.size()) begin errors++; $display("FAIL rand_count: got %0d bytes want %0d", xfer_dat.size(), exp_dat.size()); end
      n = (xfer_dat.size() < exp_dat.size()) ? xfer_dat.size() : exp_dat.size();
      for (int i = 0; i < n; i++) begin
         checks++; if (xfer_dat[i] !== exp_dat[i] || xfer_cyc[i] !== exp_cyc[i]) begin
            errors++; $display("FAIL rand_byte%0d: got %h @%0d want %h @%0d", i, xfer_dat[i], xfer_cyc[i], exp_dat[i], exp_cyc[i]);
         end
      end
      checks++; if (fe_cyc.size() !== exp_fe.size()) begin errors++; $display("FAIL rand_fe_count: got %0d want %0d", fe_cyc.size(), exp_fe.size()); end
      else begin
         for (int i = 0; i < exp_fe.size(); i++) begin
            checks++; if (fe_cyc[i] !== exp_fe[i]) begin errors++; $display("FAIL rand_fe%0d: got %0d want %0d", i, fe_cyc[i], exp_fe[i]); end
         end
      end
      checks++; if (ov_cyc.size() !== 0) begin errors++; $display("FAIL rand_ov: got %0d pulses want 0", ov_cyc.size()); end
   endtask

   initial begin
      reset = 1'b1; rx = 1'b1; ready = 1'b0;
      test_reset();
      test_normal();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Single-clock UART receiver: 8 data bits, no parity, 1 stop bit, LSB first. Oversamples the asynchronous `rx` line 16× using an internal tick divider derived from `CLKF` and `BR`, then presents each received byte on a valid/ready interface. It is the receive-side counterpart to the baud-rate timing used by the UART transmit path. It runs directly on the system clock and does not consume any generated clock.

## Interface
Parameters:
- `BR`, default 115200: baud rate in bits/s.
- `CLKF`, default 18_432_000: `clk` frequency in Hz.
- `DIV`, default `CLKF/(BR*16)`: derived localparam, the clocks per oversample tick.
- Elaboration `$fatal` if any of these hold:
  - `BR == 0` or `CLKF == 0`.
  - `CLKF % (BR*16) != 0`.
  - `DIV < 1`.

Ports:
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: asynchronous serial line; idles high.
- `data`, output, 8: received byte. Held stable while `valid` is high.
- `valid`, output, 1: a byte is available on `data`.
- `ready`, input, 1: consumer accepts the byte. A transfer occurs on any cycle with `valid && ready`.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, output, 1: one-cycle pulse when a completed byte is dropped.
- `busy`, output, 1: FSM is not in IDLE.

## Operation
- **Synchronizer:** two flops on `rx`, both reset to 1; `rx_s` is the output of the second flop. All sampling uses `rx_s`.
- **Tick counter:**
  - Width `$clog2(DIV)` (minimum 1 bit).
  - Cleared on entry to START.
  - Counts 0..DIV-1; `tick` is asserted in the cycle the count equals DIV-1, and the count then wraps to 0.
  - A 4-bit oversample counter counts ticks.
  - A 3-bit bit index counts data bits.
- **FSM states:**
  - **IDLE:** if `rx_s == 0`, go to START and clear the tick and oversample counters.
  - **START:** on the 8th tick (mid start bit), sample `rx_s`.
    - If 0: go to DATA and clear the oversample counter and bit index.
    - If 1: this is a false start; go to IDLE with no output.
  - **DATA:** on every 16th tick, shift `rx_s` into the shift register at bit[7] (shift right, so LSB-first data lands correctly). After bit index 7 is sampled, go to STOP.
  - **STOP:** on the 16th tick, sample `rx_s`.
    - If 1: deliver the byte (see output rules) and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte (`valid` and `data` unchanged), and go to BREAK.
  - **BREAK:** wait until `rx_s == 1`, then go to IDLE. This prevents a held-low line from being re-detected as a start bit.
- **Output rules at byte delivery:**
  - If `valid == 0`, or `valid && ready` in the same cycle: load `data` and set `valid` to 1.
  - Otherwise: pulse `overrun`; `data` and `valid` are unchanged, so the new byte is lost.
- **Consumer handshake:** `valid` clears on the cycle after `valid && ready`, unless a new byte loads in that same cycle.
- **Reset:** `reset` mid-frame aborts immediately. No partial byte is delivered.

## Timing
- **Reset values:**
  - `data` = 0x00.
  - `valid` = 0.
  - `frame_err` = 0.
  - `overrun` = 0.
  - `busy` = 0.
  - State IDLE, all counters 0, both synchronizer flops 1.
- **Reference cycle:** cycle 0 is the edge at which the first synchronizer flop captures `rx` low.
- **Frame timeline:**
  - `rx_s` is low at cycle 1.
  - START is entered at cycle 2.
  - The start bit is sampled at cycle 8·DIV+1.
  - Data bit i is sampled at cycle (8+16(i+1))·DIV+1.
  - The stop bit is sampled at cycle 152·DIV+1.
- **Outputs:** `valid`, or the `frame_err` pulse, is first visible at cycle 152·DIV+2. The `overrun` pulse appears in the same cycle.
- **`busy`:** high from cycle 2 until the cycle after the return to IDLE.
- **Next frame:** the earliest next start detection is in the IDLE cycle after the stop sample. This allows back-to-back frames with a stop bit of exactly one bit time.
- **Baud tolerance:** the mid-bit sampling point tolerates about ±4% total baud mismatch over a frame.

## Test plan
Bench setup: `BR=115200`, `CLKF=18_432_000`, so DIV=10 and one bit is 160 clocks.
- **Normal byte:** send 0xA5 with a valid stop bit and `ready=1` → `data=0xA5`, `valid` high for exactly cycle 1522, `frame_err=0`, `overrun=0`.
- **False start:** drive `rx` low for 30 clocks, then high → `busy` returns to 0 after the START sample; `valid` never rises.
- **Framing error:** send 0x3C with the stop bit low and the line held low for 400 further clocks → `frame_err` pulses for one cycle at cycle 1522; `valid` stays 0; no start is detected until `rx` goes high. A following 0x3C with a correct stop bit is then received correctly.
- **Overrun:** hold `ready=0` and send 0x11 then 0x22 back-to-back → `data` stays 0x11 with `valid=1`; `overrun` pulses at the second byte's stop sample. Raising `ready` then clears `valid` on the next cycle.
- **Back-to-back stress:** with `ready=1`, send 0x00 then 0xFF back-to-back → two `valid` pulses 1600 cycles apart, carrying 0x00 then 0xFF.
- **Reset mid-byte:** assert `reset` for one cycle during data bit 4 of 0x5A → all outputs at reset values on the next cycle and no `valid`. A subsequent 0xC3 is received correctly.
